ltssm_rx_detect_seq: RTL
========================

# ltssm_rx_detect_seq

Sequences the PCIe Detect.Active receiver-detection procedure for a multi-lane link. On a start request from the detect substate machine, it drives per-lane receiver-detect requests to the PHY and collects the per-lane results. When some lanes respond and others do not, it waits a fixed time and repeats the detection. It then reports one of two outcomes, goto Polling with the set of usable lanes or return to Detect.Quiet, and sits between the LTSSM detect controller and the PHY electrical layer.

## Interface
- `NUM_LANES`, 4: number of physical lanes.
- `WAIT_CYCLES`, 1200000: length of the retry wait between detection passes, in clocks (12 ms at 100 MHz).
- `PHY_TIMEOUT`, 4096: maximum clocks to wait for `phy_done_i` in one pass.

- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  begin a detection sequence; sampled only in IDLE.
- `abort_i`  in  1  cancel the sequence from any state; returns to IDLE with no `done_o`.
- `lane_mask_i`  in  NUM_LANES  unconfigured lanes to test; captured on accepted start.
- `rxdet_req_o`  out  NUM_LANES  per-lane receiver-detect request to the PHY.
- `phy_done_i`  in  1  PHY detection pass complete; `phy_status_i` is valid in the same cycle.
- `phy_status_i`  in  NUM_LANES  per-lane receiver present.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse when a result is available.
- `goto_polling_o`  out  1  result flag; valid from `done_o` until the next accepted start.
- `goto_quiet_o`  out  1  result flag; exactly one of `goto_polling_o` / `goto_quiet_o` is set at `done_o`.
- `lanes_active_o`  out  NUM_LANES  lanes to carry into Polling; zero when `goto_quiet_o` is set.
- `timeout_o`  out  1  set with `done_o` if either pass hit `PHY_TIMEOUT`.

## Operation
- States are IDLE, DET1, WAIT, DET2 and DONE.
- **IDLE:** on `start_i` capture `mask_q = lane_mask_i` and clear all result registers. If `lane_mask_i == 0`, go to DONE with quiet; otherwise go to DET1.
- **DET1 / DET2:**
  - `rxdet_req_o = mask_q`; it is zero in every other state.
  - A per-pass counter runs.
  - On `phy_done_i`, `det = phy_status_i & mask_q`. Status bits outside `mask_q` are ignored.
  - If the counter reaches `PHY_TIMEOUT` first, take `det = 0` and set `timeout_o`.
- **DET1 exit:**
  - `det == 0` → DONE with quiet.
  - `det == mask_q` → DONE with polling, `lanes_active = mask_q`.
  - Otherwise store `det1_q = det` and go to WAIT.
- **WAIT:** a down-counter loaded with `WAIT_CYCLES - 1` on entry moves to DET2 when it reaches 0.
- **DET2 exit:**
  - `det == det1_q` → DONE with polling, `lanes_active = det1_q`.
  - Otherwise → DONE with quiet.
- **DONE:** `done_o = 1` for one cycle, then IDLE. Result outputs hold until the next accepted start.
- **abort_i** has priority over every other transition. The next state is IDLE, `rxdet_req_o` drops the next cycle, and result outputs are cleared.
- `start_i` while `busy_o` is ignored.

## Timing
- Reset values: state IDLE, all outputs 0, all counters 0.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Start accepted at cycle 0 → `rxdet_req_o` asserted at cycle 1.
- `phy_done_i` seen at cycle k → `rxdet_req_o` low at k+1. The next state is DONE or WAIT at k+1.
- Single-pass latency: `done_o` at k+1.
- Retry path: DET2 entered exactly `WAIT_CYCLES` cycles after WAIT entry.
- Timeout: with no `phy_done_i`, the pass ends `PHY_TIMEOUT` cycles after entering the DET state.
- `phy_done_i` on the same cycle as the timeout: `phy_done_i` wins.
- Zero-mask start: `done_o` at cycle 1 with `goto_quiet_o`; no request is ever issued.
- Reset mid-operation: immediate return to IDLE; `rxdet_req_o` drops asynchronously.

## Structure
- Add to `ltssm_pkg`: `rxdet_sm_e` (IDLE, DET1, WAIT, DET2, DONE) and `rxdet_result_e` (RXDET_NONE, RXDET_POLLING, RXDET_QUIET).
- Counter widths: `$clog2(WAIT_CYCLES)` and `$clog2(PHY_TIMEOUT+1)`.
- One natural sub-module, `rxdet_wait_cnt`: a loadable down-counter with `load`/`en` inputs and a `zero` output, used for both the wait and the PHY timeout.

## Test plan
Bench settings: NUM_LANES=4, WAIT_CYCLES=8, PHY_TIMEOUT=16.
- **All present:** mask 4'b1111, status 4'b1111 with done at cycle 3 → `rxdet_req_o` = 4'b1111 for cycles 1–3; `done_o` at cycle 4 with polling, lanes 4'b1111.
- **None present:** mask 4'b0011, status 4'b0000 → `done_o` with `goto_quiet_o`, lanes 4'b0000; status bits 3:2 high are ignored.
- **Partial, consistent:** mask 4'b1111, status 4'b0101 on both passes → DET2 entered 8 cycles after WAIT entry; polling, lanes 4'b0101.
- **Partial, mismatch:** first pass 4'b0101, second pass 4'b0100 → `goto_quiet_o`, lanes 0.
- **PHY timeout:** no `phy_done_i` → `done_o` 17 cycles after start, with quiet and `timeout_o=1`.
- **Abort and reset:** `abort_i` during WAIT → IDLE next cycle, no `done_o`, outputs 0. `rst_i` asserted in DET1 → `rxdet_req_o` 0 immediately. `start_i` while busy → ignored.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared LTSSM types for the detect sequencing blocks.
package ltssm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DET1,
    WAIT,
    DET2,
    DONE
  } rxdet_sm_e;

  typedef enum logic [1:0] {
    RXDET_NONE,
    RXDET_POLLING,
    RXDET_QUIET
  } rxdet_result_e;

endpackage

// File: rtl/rxdet_wait_cnt.sv
// Loadable down-counter that saturates at zero; paces both the retry wait and the PHY timeout.
module rxdet_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ltssm_rx_detect_seq.sv
// Detect.Active receiver-detection sequencer: one or two PHY passes separated by a fixed wait,
// resolving to Polling with a lane set or back to Detect.Quiet.
module ltssm_rx_detect_seq
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int WAIT_CYCLES = 1200000,
  parameter int PHY_TIMEOUT = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [NUM_LANES-1:0] lane_mask_i,
  output logic [NUM_LANES-1:0] rxdet_req_o,
  input  logic                 phy_done_i,
  input  logic [NUM_LANES-1:0] phy_status_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 goto_polling_o,
  output logic                 goto_quiet_o,
  output logic [NUM_LANES-1:0] lanes_active_o,
  output logic                 timeout_o
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int TMO_W  = $clog2(PHY_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(PHY_TIMEOUT - 1);

  rxdet_sm_e              state_q, state_d;
  rxdet_result_e          result_q, result_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [NUM_LANES-1:0]   det1_q, det1_d;
  logic [NUM_LANES-1:0]   lanes_q, lanes_d;
  logic [NUM_LANES-1:0]   rxdet_req_q, rxdet_req_d;
  logic                   timeout_q, timeout_d;

  logic                   wait_load, wait_en, wait_zero;
  logic                   tmo_load, tmo_en, tmo_zero;
  logic                   pass_end, pass_tmo;
  logic [NUM_LANES-1:0]   det;

  rxdet_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (wait_load),
    .en_i       (wait_en),
    .load_val_i (WAIT_LOAD),
    .zero_o     (wait_zero)
  );

  rxdet_wait_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmo_load),
    .en_i       (tmo_en),
    .load_val_i (TMO_LOAD),
    .zero_o     (tmo_zero)
  );

  // A PHY report in the same cycle as the timeout takes precedence.
  assign pass_end = phy_done_i || tmo_zero;
  assign pass_tmo = !phy_done_i && tmo_zero;
  assign det      = phy_done_i ? (phy_status_i & mask_q) : '0;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mask_d    = mask_q;
    det1_d    = det1_q;
    lanes_d   = lanes_q;
    timeout_d = timeout_q;
    wait_load = 1'b0;
    wait_en   = 1'b0;
    tmo_load  = 1'b0;
    tmo_en    = 1'b0;

    if (abort_i) begin
      state_d   = IDLE;
      result_d  = RXDET_NONE;
      lanes_d   = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mask_d    = lane_mask_i;
            det1_d    = '0;
            result_d  = RXDET_NONE;
            lanes_d   = '0;
            timeout_d = 1'b0;
            if (lane_mask_i == '0) begin
              state_d  = DONE;
              result_d = RXDET_QUIET;
            end else begin
              state_d  = DET1;
              tmo_load = 1'b1;
            end
          end
        end
        DET1: begin
          tmo_en = 1'b1;
          if (pass_end) begin
            timeout_d = timeout_q | pass_tmo;
            if (det == '0) begin
              state_d  = DONE;
              result_d = RXDET_QUIET;
            end else if (det == mask_q) begin
              state_d  = DONE;
              result_d = RXDET_POLLING;
              lanes_d  = mask_q;
            end else begin
              // Some lanes answered: remember which, then retry after the wait.
              det1_d    = det;
              state_d   = WAIT;
              wait_load = 1'b1;
            end
          end
        end
        WAIT: begin
          wait_en = 1'b1;
          if (wait_zero) begin
            state_d  = DET2;
            tmo_load = 1'b1;
          end
        end
        DET2: begin
          tmo_en = 1'b1;
          if (pass_end) begin
            timeout_d = timeout_q | pass_tmo;
            state_d   = DONE;
            if (det == det1_q) begin
              result_d = RXDET_POLLING;
              lanes_d  = det1_q;
            end else begin
              result_d = RXDET_QUIET;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    rxdet_req_d = ((state_d == DET1) || (state_d == DET2)) ? mask_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      result_q    <= RXDET_NONE;
      mask_q      <= '0;
      det1_q      <= '0;
      lanes_q     <= '0;
      timeout_q   <= 1'b0;
      rxdet_req_q <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      mask_q      <= mask_d;
      det1_q      <= det1_d;
      lanes_q     <= lanes_d;
      timeout_q   <= timeout_d;
      rxdet_req_q <= rxdet_req_d;
    end
  end

  assign rxdet_req_o    = rxdet_req_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign goto_polling_o = (result_q == RXDET_POLLING);
  assign goto_quiet_o   = (result_q == RXDET_QUIET);
  assign lanes_active_o = lanes_q;
  assign timeout_o      = timeout_q;

endmodule
